// File: rtl/branch_dir_predictor_pkg.sv
// Shared definitions for the branch-direction predictor.
//   cnt_t            2-bit saturating counter value
//   CNT_SNT..CNT_ST  strongly/weakly not-taken, weakly/strongly taken
//   BDP_PC_IDX       table index from a word-aligned PC (bits [w+1:2])
`ifndef BRANCH_DIR_PREDICTOR_PKG_SV
`define BRANCH_DIR_PREDICTOR_PKG_SV

`define BDP_PC_IDX(pc, w) pc[(w)+1:2]

package branch_dir_predictor_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT = 2'b00;
  localparam cnt_t CNT_WNT = 2'b01;
  localparam cnt_t CNT_WT  = 2'b10;
  localparam cnt_t CNT_ST  = 2'b11;

endpackage

`endif

// File: rtl/branch_dir_predictor_if.sv
// Pipeline-side bundle of the branch-direction predictor.
//   master : pipeline (drives PC, IF/ID control, ID branch outcome)
//   slave  : predictor (returns prediction, mispredict, statistics)
interface branch_dir_predictor_if #(
  parameter int STAT_W = 32
);
  logic [31:0]       if_pc;
  logic              if_pred_taken;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_is_branch;
  logic              id_cond_true;
  logic              id_stall;
  logic              id_pred_taken;
  logic              mispredict;
  logic              actual_taken;
  logic [STAT_W-1:0] br_count;
  logic [STAT_W-1:0] mp_count;

  modport master (
    output if_pc, if_id_en, if_id_flush, id_is_branch, id_cond_true, id_stall,
    input  if_pred_taken, id_pred_taken, mispredict, actual_taken, br_count, mp_count
  );

  modport slave (
    input  if_pc, if_id_en, if_id_flush, id_is_branch, id_cond_true, id_stall,
    output if_pred_taken, id_pred_taken, mispredict, actual_taken, br_count, mp_count
  );
endinterface

// File: rtl/branch_dir_predictor_sat_counter2.sv
// 2-bit saturating up/down counter next-state function.
//   cnt      current counter value
//   taken    1: count up (saturate at CNT_ST), 0: count down (saturate at CNT_SNT)
//   cnt_nxt  trained value
module sat_counter2
  import branch_dir_predictor_pkg::*;
(
  input  cnt_t cnt,
  input  logic taken,
  output cnt_t cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    if (taken) begin
      if (cnt != CNT_ST) cnt_nxt = cnt + 2'b01;
    end else begin
      if (cnt != CNT_SNT) cnt_nxt = cnt - 2'b01;
    end
  end

endmodule

// File: rtl/branch_dir_predictor.sv
// Branch-direction predictor: table of 2-bit saturating counters indexed by PC.
//   clk, rst_n  system clock, asynchronous active-low reset
//   bus         slave side of branch_dir_predictor_if
//     IF side : if_pc -> if_pred_taken (combinational table read)
//     ID side : id_is_branch/id_cond_true/id_stall -> mispredict, actual_taken,
//               id_pred_taken (prediction carried with the ID instruction)
//     stats   : br_count (resolved branches), mp_count (mispredicts)
module branch_dir_predictor
  import branch_dir_predictor_pkg::*;
#(
  parameter int   IDX_W   = 6,
  parameter cnt_t CNT_RST = CNT_WNT,
  parameter int   STAT_W  = 32
) (
  input logic clk,
  input logic rst_n,
  branch_dir_predictor_if.slave bus
);

  localparam int DEPTH = 1 << IDX_W;

  cnt_t              tbl_q [DEPTH];
  logic [IDX_W-1:0]  idx_if;
  logic              id_valid_q;
  logic              id_pred_q;
  logic [IDX_W-1:0]  id_idx_q;
  logic              resolve;
  logic              mispredict;
  cnt_t              cnt_upd;
  logic [STAT_W-1:0] br_cnt_q;
  logic [STAT_W-1:0] mp_cnt_q;
  logic              unused_pc_bits;

  assign idx_if         = `BDP_PC_IDX(bus.if_pc, IDX_W);
  assign unused_pc_bits = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0]};

  // Read returns the pre-update entry when ID trains the same index this cycle.
  assign bus.if_pred_taken = tbl_q[idx_if][1];

  assign resolve    = id_valid_q & bus.id_is_branch & ~bus.id_stall;
  assign mispredict = resolve & (bus.id_cond_true != id_pred_q);

  assign bus.mispredict    = mispredict;
  assign bus.actual_taken  = mispredict & bus.id_cond_true;
  assign bus.id_pred_taken = id_pred_q;
  assign bus.br_count      = br_cnt_q;
  assign bus.mp_count      = mp_cnt_q;

  sat_counter2 u_sat (
    .cnt     (tbl_q[id_idx_q]),
    .taken   (bus.id_cond_true),
    .cnt_nxt (cnt_upd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= CNT_RST;
    end else if (resolve) begin
      tbl_q[id_idx_q] <= cnt_upd;
    end
  end

  // A flush still lets a resolving branch train and count on this edge; the
  // record only turns into a bubble afterwards. idx is kept across a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      id_pred_q  <= 1'b0;
      id_idx_q   <= '0;
    end else if (bus.if_id_flush) begin
      id_valid_q <= 1'b0;
      id_pred_q  <= 1'b0;
    end else if (bus.if_id_en) begin
      id_valid_q <= 1'b1;
      id_pred_q  <= bus.if_pred_taken;
      id_idx_q   <= idx_if;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_q + {{(STAT_W-1){1'b0}}, resolve};
      mp_cnt_q <= mp_cnt_q + {{(STAT_W-1){1'b0}}, mispredict};
    end
  end

endmodule
